// File: rtl/rv_lsu.sv
// rv_lsu: single-outstanding load/store unit between the core and a word-addressed data port.
// Optional misaligned-access rejection is compiled in with `define RV_LSU_MISALIGN_CHECK_EN.
module rv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_stall_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_byte, is_half, misaligned, resp_done;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Codes other than B/H (with or without U) fall through to word handling.
    assign is_byte = (lsu_size_i[1:0] == 2'b00);
    assign is_half = (lsu_size_i[1:0] == 2'b01);

`ifdef RV_LSU_MISALIGN_CHECK_EN
    assign misaligned = (is_half & lsu_addr_i[0]) |
                        (!is_byte & !is_half & (lsu_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = lsu_wdata_i;
        if (is_byte) begin
            be_new    = 4'b0001 << lsu_addr_i[1:0];
            wdata_new = {4{lsu_wdata_i[7:0]}};
        end else if (is_half) begin
            be_new    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{lsu_wdata_i[15:0]}};
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = data_rdata_i[7:0];
            2'd1:    byte_sel = data_rdata_i[15:8];
            2'd2:    byte_sel = data_rdata_i[23:16];
            default: byte_sel = data_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q[1:0])
            2'b00:   load_val = {{24{!size_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{!size_q[2] & half_sel[15]}}, half_sel};
            default: load_val = data_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        waddr_d     = waddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        lsu_stall_o = 1'b0;
        data_req_o  = 1'b0;
        resp_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i && !misaligned) begin
                    lsu_stall_o = 1'b1;
                    state_d     = REQ;
                    we_d        = lsu_we_i;
                    size_d      = lsu_size_i;
                    off_d       = lsu_addr_i[1:0];
                    waddr_d     = lsu_addr_i[31:2];
                    be_d        = be_new;
                    wdata_d     = wdata_new;
                end
            end
            REQ: begin
                data_req_o  = 1'b1;
                lsu_stall_o = 1'b1;
                if (data_gnt_i) state_d = RESP;
            end
            RESP: begin
                if (data_rvalid_i) begin
                    state_d   = IDLE;
                    resp_done = 1'b1;
                    if (!we_q) rdata_d = load_val;
                end else begin
                    lsu_stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loads forward the fresh word in the release cycle; otherwise show the last load.
        lsu_rdata_o = (resp_done && !we_q) ? load_val : rdata_q;
        if (rst_i) begin
            lsu_stall_o = 1'b0;
            data_req_o  = 1'b0;
            lsu_rdata_o = '0;
        end
    end

    assign lsu_misaligned_o = !rst_i && (state_q == IDLE) && lsu_req_i && misaligned;
    assign data_we_o        = we_q;
    assign data_be_o        = be_q;
    assign data_addr_o      = {waddr_q, 2'b00};
    assign data_wdata_o     = wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: scoreboard bench for rv_lsu with a behavioural memory responder and reference model.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        lsu_stall_o, lsu_misaligned_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    always #5 clk = ~clk;

    rv_lsu dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
        .lsu_stall_o(lsu_stall_o), .lsu_misaligned_o(lsu_misaligned_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic we; logic [2:0] size; logic [1:0] off; } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_last = '0;

    // memory responder knobs/state
    bit mem_auto, spurious_en, rd_fix_en, owe, hs_armed, req_seen;
    int g_fix, r_fix, gwait, rwait;
    logic [31:0] rd_fix;
    bit mon_en;

    // values seen by the driver during the last access
    logic [3:0]  seen_be;
    logic [31:0] seen_addr, seen_wdata, seen_rd;
    int          seen_req_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
        int unsigned off = a % 4;
        if (sz == 3'd0 || sz == 3'd4) return 4'(1 << off);
        if (sz == 3'd1 || sz == 3'd5) return 4'(3 << (2 * (off / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] wd);
        if (sz == 3'd0 || sz == 3'd4) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 3'd1 || sz == 3'd5) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input int unsigned off,
                                             input logic [31:0] word);
        int unsigned v;
        if (sz == 3'd0 || sz == 3'd4) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (sz == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 3'd1 || sz == 3'd5) begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (sz == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return word;
    endfunction

    // Memory model: grants after a (fixed or random) wait, answers once per grant.
    task automatic mem_step();
        if (!mem_auto) return;
        if (owe && data_rvalid_i) owe = 1'b0;
        if (hs_armed && !rst_i) begin
            owe   = 1'b1;
            rwait = (r_fix >= 0) ? r_fix : int'($urandom_range(0, 3));
        end
        hs_armed = 1'b0;
        if (data_req_o) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                gwait    = (g_fix >= 0) ? g_fix : int'($urandom_range(0, 3));
            end
            if (gwait == 0) begin
                data_gnt_i = 1'b1;
                hs_armed   = 1'b1;
                req_seen   = 1'b0;
            end else begin
                data_gnt_i = 1'b0;
                gwait--;
            end
        end else begin
            data_gnt_i = 1'b0;
        end
        if (owe) begin
            if (rwait == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rd_fix_en ? rd_fix : $urandom();
            end else begin
                data_rvalid_i = 1'b0;
                data_rdata_i  = $urandom();
                rwait--;
            end
        end else begin
            data_rvalid_i = spurious_en && ($urandom_range(0, 3) == 0);
            data_rdata_i  = $urandom();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic do_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, output int stall_cyc);
        req_t e;
        rsp_t r;
        logic stalled;
        int   cyc;
        bit   got_req;
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = sz;
        lsu_addr_i  = addr;
        lsu_wdata_i = wd;
        e.addr  = addr & ~32'h3;
        e.be    = ref_be(sz, addr);
        e.we    = we;
        e.wdata = ref_wdata(sz, wd);
        req_q.push_back(e);
        r.we   = we;
        r.size = sz;
        r.off  = addr[1:0];
        rsp_q.push_back(r);
        cyc = 0;
        got_req = 1'b0;
        seen_req_cyc = -1;
        forever begin
            @(negedge clk);
            stalled = lsu_stall_o;
            if (data_req_o && !got_req) begin
                got_req      = 1'b1;
                seen_be      = data_be_o;
                seen_addr    = data_addr_o;
                seen_wdata   = data_wdata_o;
                seen_req_cyc = cyc;
            end
            if (!stalled) seen_rd = lsu_rdata_o;
            tick();
            cyc++;
            if (!stalled) break;
            if (cyc > 100) begin
                checks++;
                errors++;
                $display("FAIL access_timeout actual=%0d cycles required=release", cyc);
                break;
            end
        end
        stall_cyc = cyc - 1;
    endtask

    // Monitor: compares memory-side requests and core-side releases against the queues.
    always @(negedge clk) begin : monitor
        req_t        e;
        rsp_t        r;
        logic [31:0] exp_rd;
        if (rst_i) mdl_last = '0;
        if (mon_en) begin
            if (data_req_o) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=%h required=none", data_addr_o);
                end else begin
                    e = req_q[0];
                    chk("req_addr", data_addr_o, e.addr);
                    chk("req_be", {28'd0, data_be_o}, {28'd0, e.be});
                    chk("req_we", {31'd0, data_we_o}, {31'd0, e.we});
                    chk("req_wdata", data_wdata_o, e.wdata);
                    if (data_gnt_i) void'(req_q.pop_front());
                end
            end
            if (owe && data_rvalid_i) begin
                chk("release_stall", {31'd0, lsu_stall_o}, 32'd0);
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release actual=%h required=none", lsu_rdata_o);
                end else begin
                    r = rsp_q.pop_front();
                    exp_rd = r.we ? mdl_last : ref_load(r.size, r.off, data_rdata_i);
                    chk("lsu_rdata", lsu_rdata_o, exp_rd);
                    if (!r.we) mdl_last = exp_rd;
                end
            end else begin
                chk("stall", {31'd0, lsu_stall_o}, {31'd0, lsu_req_i});
            end
            chk("misaligned", {31'd0, lsu_misaligned_o}, 32'd0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int          sc, sc2;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a;
        rst_i = 1'b1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2;
        lsu_addr_i = 32'h0000_0400; lsu_wdata_i = 32'h1234_5678;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        mem_auto = 1'b1; spurious_en = 1'b0; rd_fix_en = 1'b0; rd_fix = '0;
        owe = 1'b0; hs_armed = 1'b0; req_seen = 1'b0; g_fix = 0; r_fix = 0;
        gwait = 0; rwait = 0; mon_en = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", {31'd0, lsu_stall_o}, 32'd0);
            chk("rst_req", {31'd0, data_req_o}, 32'd0);
            chk("rst_rdata", lsu_rdata_o, 32'd0);
            chk("rst_mis", {31'd0, lsu_misaligned_o}, 32'd0);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        lsu_req_i = 1'b0;
        @(negedge clk);
        chk("rst_be", {28'd0, data_be_o}, 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        mon_en = 1'b1;
        tick();

        // LB with immediate grant/response
        rd_fix_en = 1'b1; rd_fix = 32'h8000_0000;
        do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, sc);
        chk("lb_be", {28'd0, seen_be}, 32'h8);
        chk("lb_addr", seen_addr, 32'h0000_0100);
        chk("lb_rdata", seen_rd, 32'hFFFF_FF80);
        chk("lb_stall_cycles", sc, 2);

        // LHU upper half
        rd_fix = 32'hBEEF_1234;
        do_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, sc);
        chk("lhu_be", {28'd0, seen_be}, 32'hC);
        chk("lhu_rdata", seen_rd, 32'h0000_BEEF);

        // SB with grant held off for three cycles
        g_fix = 3;
        do_access(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, sc);
        chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
        chk("sb_be", {28'd0, seen_be}, 32'h2);
        chk("sb_stall_cycles", sc, 5);
        chk("sb_rdata_kept", seen_rd, 32'h0000_BEEF);

        // back-to-back word loads
        g_fix = 0; r_fix = 0; rd_fix_en = 1'b0;
        do_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, sc);
        do_access(1'b0, 3'b010, 32'h0000_0014, 32'h0, sc2);
        chk("b2b_first_cycles", sc, 2);
        chk("b2b_second_cycles", sc2, 2);
        chk("b2b_second_req_cycle", seen_req_cyc, 1);
        chk("b2b_second_addr", seen_addr, 32'h0000_0014);

        // misaligned word load
`ifdef RV_LSU_MISALIGN_CHECK_EN
        mon_en = 1'b0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h0000_0402;
        repeat (3) begin
            @(negedge clk);
            chk("mis_flag", {31'd0, lsu_misaligned_o}, 32'd1);
            chk("mis_stall", {31'd0, lsu_stall_o}, 32'd0);
            chk("mis_req", {31'd0, data_req_o}, 32'd0);
            tick();
        end
        lsu_req_i = 1'b0;
        tick();
        mon_en = 1'b1;
`else
        do_access(1'b0, 3'b010, 32'h0000_0402, 32'h0, sc);
        chk("lw_mis_addr", seen_addr, 32'h0000_0400);
        chk("lw_mis_be", {28'd0, seen_be}, 32'hF);
        chk("lw_mis_cycles", sc, 2);
`endif

        // randomized traffic with random memory timing and spurious rvalid
        g_fix = -1; r_fix = -1; spurious_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = $urandom();
`ifdef RV_LSU_MISALIGN_CHECK_EN
            if (sz[1:0] == 2'b01) a[0] = 1'b0;
            else if (sz[1:0] != 2'b00) a[1:0] = 2'b00;
`endif
            do_access(we, sz, a, $urandom(), sc);
            if ($urandom_range(0, 1) == 1) begin
                lsu_req_i = 1'b0;
                lsu_addr_i = $urandom();
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        lsu_req_i = 1'b0;
        spurious_en = 1'b0;
        tick();
        tick();

        // reset while waiting for the response, then a stale rvalid
        mon_en = 1'b0; mem_auto = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h0000_0040;
        tick();
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0; rst_i = 1'b1; lsu_req_i = 1'b0;
        @(negedge clk);
        chk("rst_resp_stall", {31'd0, lsu_stall_o}, 32'd0);
        chk("rst_resp_rdata", lsu_rdata_o, 32'd0);
        tick();
        rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("stale_rv_stall", {31'd0, lsu_stall_o}, 32'd0);
        chk("stale_rv_rdata", lsu_rdata_o, 32'd0);
        chk("stale_rv_req", {31'd0, data_req_o}, 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        @(negedge clk);
        chk("after_stale_rdata", lsu_rdata_o, 32'd0);
        owe = 1'b0; hs_armed = 1'b0; req_seen = 1'b0;
        mem_auto = 1'b1; mon_en = 1'b1;
        g_fix = 0; r_fix = 0;
        tick();
        do_access(1'b1, 3'b010, 32'h0000_0080, 32'h1234_5678, sc);
        chk("post_rst_store_rdata", seen_rd, 32'd0);
        chk("post_rst_cycles", sc, 2);
        lsu_req_i = 1'b0;
        tick();
        chk("queues_drained", req_q.size() + rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
